// File: rtl/btle_rx_scan_ctrl.sv
// Scan/receive sequencer for btle_rx_core: arms the core, runs listen windows on one channel
// or sweeps advertising channels 37/38/39, and reports decoded packets with packet/CRC counters.
module btle_rx_scan_ctrl #(
  parameter int unsigned WINDOW_BIT_WIDTH = 20,
  parameter logic [19:0] GUARD_CYCLES     = 20'd1000000,
  parameter int unsigned ARM_CYCLES       = 2,
  parameter logic [31:0] ADV_UNIQUE_BITS  = 32'h8E89BED6,
  parameter logic [23:0] ADV_CRC_INIT     = 24'h555555
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        cfg_sweep,
  input  logic [5:0]                  cfg_channel,
  input  logic [31:0]                 cfg_unique_bits,
  input  logic [23:0]                 cfg_crc_init,
  input  logic [WINDOW_BIT_WIDTH-1:0] window_len,
  input  logic                        core_hit,
  input  logic [6:0]                  core_len,
  input  logic                        core_decode_end,
  input  logic                        core_crc_ok,
  output logic                        core_rst,
  output logic [5:0]                  channel_number,
  output logic [31:0]                 unique_bits,
  output logic [23:0]                 crc_init,
  output logic                        busy,
  output logic                        pkt_done,
  output logic                        pkt_crc_ok,
  output logic [5:0]                  pkt_channel,
  output logic [6:0]                  pkt_len,
  output logic                        window_done,
  output logic [15:0]                 pkt_cnt,
  output logic [15:0]                 crc_err_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_LISTEN  = 3'd2;
  localparam logic [2:0] S_RECEIVE = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_HOP     = 3'd5;

  localparam logic [5:0] CH_37 = 6'd37;
  localparam logic [5:0] CH_38 = 6'd38;
  localparam logic [5:0] CH_39 = 6'd39;

  localparam int unsigned ARM_W = $clog2(ARM_CYCLES + 1);

  logic [2:0]                  state;
  logic [2:0]                  state_nxt;
  logic                        sweep;
  logic [ARM_W-1:0]            arm_cnt;
  logic [WINDOW_BIT_WIDTH-1:0] win_cnt;
  logic [19:0]                 guard_cnt;
  logic                        win_expire;
  logic                        take_pkt;
  logic                        launch;
  logic [5:0]                  next_adv;

  // stop is checked first in every busy state so it beats hit, decode_end and expiries
  always_comb begin
    state_nxt  = state;
    win_expire = 1'b0;
    take_pkt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (stop)                state_nxt = S_IDLE;
        else if (arm_cnt == '0)  state_nxt = S_LISTEN;
      end
      S_LISTEN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (core_hit) begin
          state_nxt = S_RECEIVE;
        end else if (win_cnt <= WINDOW_BIT_WIDTH'(1)) begin
          win_expire = 1'b1;
          state_nxt  = sweep ? S_HOP : S_ARM;
        end
      end
      S_RECEIVE: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (core_decode_end) begin
          take_pkt  = 1'b1;
          state_nxt = S_REPORT;
        end else if (guard_cnt <= 20'd1) begin
          state_nxt = sweep ? S_HOP : S_ARM;
        end
      end
      S_REPORT: begin
        if (stop) state_nxt = S_IDLE;
        else      state_nxt = sweep ? S_HOP : S_ARM;
      end
      S_HOP: begin
        if (stop) state_nxt = S_IDLE;
        else      state_nxt = S_ARM;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == S_IDLE) && (state_nxt == S_ARM);
    case (channel_number)
      CH_37:   next_adv = CH_38;
      CH_38:   next_adv = CH_39;
      default: next_adv = CH_37;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      core_rst       <= 1'b1;
      channel_number <= CH_37;
      unique_bits    <= '0;
      crc_init       <= '0;
      sweep          <= 1'b0;
      busy           <= 1'b0;
      pkt_done       <= 1'b0;
      pkt_crc_ok     <= 1'b0;
      pkt_channel    <= '0;
      pkt_len        <= '0;
      window_done    <= 1'b0;
      pkt_cnt        <= '0;
      crc_err_cnt    <= '0;
      arm_cnt        <= '0;
      win_cnt        <= '0;
      guard_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != S_IDLE);
      // core is released only while listening or receiving; every other state re-resets it
      core_rst    <= !((state_nxt == S_LISTEN) || (state_nxt == S_RECEIVE));
      window_done <= win_expire;
      pkt_done    <= take_pkt;

      if (launch) begin
        sweep          <= cfg_sweep;
        channel_number <= cfg_sweep ? CH_37 : cfg_channel;
        unique_bits    <= cfg_sweep ? ADV_UNIQUE_BITS : cfg_unique_bits;
        crc_init       <= cfg_sweep ? ADV_CRC_INIT : cfg_crc_init;
      end

      if (state == S_HOP) channel_number <= next_adv;

      if ((state_nxt == S_ARM) && (state != S_ARM)) arm_cnt <= ARM_W'(ARM_CYCLES);
      else if (state == S_ARM)                      arm_cnt <= arm_cnt - 1'b1;

      if ((state_nxt == S_LISTEN) && (state != S_LISTEN)) win_cnt <= window_len;
      else if (state == S_LISTEN)                         win_cnt <= win_cnt - 1'b1;

      if ((state_nxt == S_RECEIVE) && (state != S_RECEIVE)) guard_cnt <= GUARD_CYCLES;
      else if (state == S_RECEIVE)                          guard_cnt <= guard_cnt - 1'b1;

      if (take_pkt) begin
        pkt_crc_ok  <= core_crc_ok;
        pkt_len     <= core_len;
        pkt_channel <= channel_number;
        pkt_cnt     <= pkt_cnt + 1'b1;
        if (!core_crc_ok) crc_err_cnt <= crc_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btle_rx_scan_ctrl.sv
// Bench for btle_rx_scan_ctrl: drives a stand-in core, predicts window/packet events into a
// queue, and a negedge monitor pops and compares whenever window_done or pkt_done fires.
module tb_btle_rx_scan_ctrl;

  localparam int unsigned WW    = 20;
  localparam int unsigned ARM   = 2;
  localparam int unsigned GUARD = 50;
  localparam logic [31:0] ADV_AA  = 32'h8E89BED6;
  localparam logic [23:0] ADV_CRC = 24'h555555;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          cfg_sweep;
  logic [5:0]    cfg_channel;
  logic [31:0]   cfg_unique_bits;
  logic [23:0]   cfg_crc_init;
  logic [WW-1:0] window_len;
  logic          core_hit;
  logic [6:0]    core_len;
  logic          core_decode_end;
  logic          core_crc_ok;
  logic          core_rst;
  logic [5:0]    channel_number;
  logic [31:0]   unique_bits;
  logic [23:0]   crc_init;
  logic          busy;
  logic          pkt_done;
  logic          pkt_crc_ok;
  logic [5:0]    pkt_channel;
  logic [6:0]    pkt_len;
  logic          window_done;
  logic [15:0]   pkt_cnt;
  logic [15:0]   crc_err_cnt;

  btle_rx_scan_ctrl #(
    .WINDOW_BIT_WIDTH(WW),
    .GUARD_CYCLES    (20'(GUARD)),
    .ARM_CYCLES      (ARM),
    .ADV_UNIQUE_BITS (ADV_AA),
    .ADV_CRC_INIT    (ADV_CRC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .cfg_sweep      (cfg_sweep),
    .cfg_channel    (cfg_channel),
    .cfg_unique_bits(cfg_unique_bits),
    .cfg_crc_init   (cfg_crc_init),
    .window_len     (window_len),
    .core_hit       (core_hit),
    .core_len       (core_len),
    .core_decode_end(core_decode_end),
    .core_crc_ok    (core_crc_ok),
    .core_rst       (core_rst),
    .channel_number (channel_number),
    .unique_bits    (unique_bits),
    .crc_init       (crc_init),
    .busy           (busy),
    .pkt_done       (pkt_done),
    .pkt_crc_ok     (pkt_crc_ok),
    .pkt_channel    (pkt_channel),
    .pkt_len        (pkt_len),
    .window_done    (window_done),
    .pkt_cnt        (pkt_cnt),
    .crc_err_cnt    (crc_err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_pkt;
    logic [5:0]  ch;
    logic [6:0]  len;
    bit          crc_ok;
    logic [15:0] pcnt;
    logic [15:0] ecnt;
    int          at;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [15:0] m_pcnt = '0;
  logic [15:0] m_ecnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // sweep order repeats 37,38,39 for every window or packet that ends on a channel
  function automatic logic [5:0] adv_ch(input int unsigned i);
    return 6'(37 + (i % 3));
  endfunction

  task automatic push_window(input logic [5:0] ch, input int at);
    ev_t e;
    e.is_pkt = 1'b0; e.ch = ch; e.len = '0; e.crc_ok = 1'b0;
    e.pcnt = m_pcnt; e.ecnt = m_ecnt; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [5:0] ch, input logic [6:0] len, input bit ok);
    ev_t e;
    m_pcnt = m_pcnt + 16'd1;
    if (!ok) m_ecnt = m_ecnt + 16'd1;
    e.is_pkt = 1'b1; e.ch = ch; e.len = len; e.crc_ok = ok;
    e.pcnt = m_pcnt; e.ecnt = m_ecnt; e.at = -1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (window_done === 1'b1 || pkt_done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {62'b0, pkt_done, window_done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", pkt_done, mon_e.is_pkt);
        if (mon_e.is_pkt) begin
          check("pkt_channel", pkt_channel, mon_e.ch);
          check("pkt_len", pkt_len, mon_e.len);
          check("pkt_crc_ok", pkt_crc_ok, mon_e.crc_ok);
          check("pkt_cnt", pkt_cnt, mon_e.pcnt);
          check("crc_err_cnt", crc_err_cnt, mon_e.ecnt);
        end else begin
          check("window_channel", channel_number, mon_e.ch);
          if (mon_e.at >= 0) check("window_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  task automatic wait_core_rst(input logic lvl, input int unsigned budget);
    int unsigned k = 0;
    while (core_rst !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_core_rst", core_rst, lvl);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("queue_drain", exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_channel"}, channel_number, 37);
    check({tag, "_unique_bits"}, unique_bits, 0);
    check({tag, "_crc_init"}, crc_init, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pkt_done"}, pkt_done, 0);
    check({tag, "_pkt_crc_ok"}, pkt_crc_ok, 0);
    check({tag, "_pkt_channel"}, pkt_channel, 0);
    check({tag, "_pkt_len"}, pkt_len, 0);
    check({tag, "_window_done"}, window_done, 0);
    check({tag, "_pkt_cnt"}, pkt_cnt, 0);
    check({tag, "_crc_err_cnt"}, crc_err_cnt, 0);
  endtask

  // all stimulus tasks are entered and left on a negedge
  task automatic do_start(input bit sw, input logic [5:0] ch, input logic [WW-1:0] w,
                          output int unsigned n);
    cfg_sweep       = sw;
    cfg_channel     = ch;
    cfg_unique_bits = $urandom;
    cfg_crc_init    = 24'($urandom);
    window_len      = w;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = cyc;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_core_rst", core_rst, 1);
  endtask

  task automatic pulse_hit();
    core_hit = 1'b1;
    @(negedge clk);
    core_hit = 1'b0;
  endtask

  task automatic send_decode(input logic [6:0] len, input bit ok);
    core_decode_end = 1'b1;
    core_len        = len;
    core_crc_ok     = ok;
    @(negedge clk);
    core_decode_end = 1'b0;
    core_len        = '0;
    core_crc_ok     = 1'b0;
  endtask

  task automatic rx_packet(input logic [5:0] ch, input int unsigned max_wait, input bit flip);
    logic [6:0]  len;
    logic [23:0] tx_crc;
    logic [23:0] rx_crc;
    bit          ok;
    len    = 7'($urandom_range(0, 127));
    tx_crc = 24'($urandom);
    rx_crc = flip ? (tx_crc ^ (24'd1 << $urandom_range(0, 23))) : tx_crc;
    ok     = (rx_crc == tx_crc);
    repeat ($urandom_range(0, max_wait)) @(negedge clk);
    pulse_hit();
    repeat ($urandom_range(0, GUARD - 20)) @(negedge clk);
    push_pkt(ch, len, ok);
    send_decode(len, ok);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int unsigned n;
  int unsigned w;
  int unsigned h;
  int unsigned adv_i;
  int unsigned kind;
  logic [5:0]  ch;

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_sweep = 1'b0; cfg_channel = '0;
    cfg_unique_bits = '0; cfg_crc_init = '0; window_len = '0;
    core_hit = 1'b0; core_len = '0; core_decode_end = 1'b0; core_crc_ok = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b1;
    @(negedge clk);

    // sweep, no hits: windows at fixed spacing on 37,38,39,37
    do_start(1'b1, 6'd5, WW'(100), n);
    for (int k = 0; k < 4; k++)
      push_window(adv_ch(k), int'(n + 1 + ARM + 100 + k * (100 + ARM + 2)));
    wait_core_rst(1'b0, 20);
    check("arm_latency", cyc, n + 1 + ARM);
    check("sweep_unique_bits", unique_bits, ADV_AA);
    check("sweep_crc_init", crc_init, ADV_CRC);
    check("sweep_busy", busy, 1);
    wait_drain(1000);
    do_stop();

    // single channel 12: good CRC, then a flipped bit, then random packets
    do_start(1'b0, 6'd12, WW'(1000), n);
    wait_core_rst(1'b0, 20);
    check("single_channel", channel_number, 12);
    check("single_unique_bits", unique_bits, cfg_unique_bits);
    check("single_crc_init", crc_init, cfg_crc_init);
    for (int p = 0; p < 6; p++) begin
      wait_core_rst(1'b0, 50);
      check("rearm_channel", channel_number, 12);
      rx_packet(6'd12, 20, (p == 1) || (p >= 2 && $urandom_range(0, 1) == 1));
    end
    wait_drain(50);
    wait_core_rst(1'b0, 50);
    check("final_rearm_channel", channel_number, 12);
    do_stop();

    // hit on the very cycle the window would expire
    w  = $urandom_range(4, 20);
    ch = 6'($urandom_range(0, 39));
    do_start(1'b0, ch, WW'(w), n);
    wait_core_rst(1'b0, 20);
    repeat (w - 1) @(negedge clk);
    pulse_hit();
    check("hit_on_expiry_receive", core_rst, 0);
    repeat ($urandom_range(0, 10)) @(negedge clk);
    push_pkt(ch, 7'd37, 1'b1);
    send_decode(7'd37, 1'b1);
    do_stop();
    wait_drain(10);

    // hit with no decode_end: guard returns to ARM after GUARD cycles
    do_start(1'b0, 6'd7, WW'(1000), n);
    wait_core_rst(1'b0, 20);
    pulse_hit();
    h = cyc;
    repeat (GUARD - 1) @(negedge clk);
    check("guard_still_receive", core_rst, 0);
    @(negedge clk);
    check("guard_elapsed", cyc - h, GUARD);
    check("guard_core_rst", core_rst, 1);
    check("guard_busy", busy, 1);
    check("guard_pkt_cnt", pkt_cnt, m_pcnt);
    check("guard_crc_err_cnt", crc_err_cnt, m_ecnt);
    wait_core_rst(1'b0, 20);
    check("guard_rearm_channel", channel_number, 7);
    do_stop();

    // stop together with decode_end
    do_start(1'b0, 6'd20, WW'(1000), n);
    wait_core_rst(1'b0, 20);
    pulse_hit();
    repeat (3) @(negedge clk);
    stop = 1'b1;
    core_decode_end = 1'b1;
    core_crc_ok = 1'b1;
    core_len = 7'd9;
    @(negedge clk);
    stop = 1'b0; core_decode_end = 1'b0; core_crc_ok = 1'b0; core_len = '0;
    check("stop_decode_busy", busy, 0);
    check("stop_decode_core_rst", core_rst, 1);
    check("stop_decode_pkt_done", pkt_done, 0);
    repeat (3) @(negedge clk);
    check("stop_decode_pkt_cnt", pkt_cnt, m_pcnt);

    // stop and start together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("start_stop_idle_busy", busy, 0);
    check("start_stop_idle_core_rst", core_rst, 1);

    // reset asserted mid-RECEIVE
    do_start(1'b0, 6'd3, WW'(1000), n);
    wait_core_rst(1'b0, 20);
    pulse_hit();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("mid_rx");
    m_pcnt = '0;
    m_ecnt = '0;
    rst = 1'b1;
    @(negedge clk);

    // randomized sweep: each listen ends in expiry, packet or guard timeout
    w = $urandom_range(30, 80);
    do_start(1'b1, 6'd0, WW'(w), n);
    adv_i = 0;
    for (int it = 0; it < 12; it++) begin
      wait_core_rst(1'b0, 200);
      check("mix_channel", channel_number, adv_ch(adv_i));
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        push_window(adv_ch(adv_i), -1);
      end else if (kind == 1) begin
        rx_packet(adv_ch(adv_i), w / 2, $urandom_range(0, 3) == 0);
      end else begin
        repeat ($urandom_range(0, w / 2)) @(negedge clk);
        pulse_hit();
      end
      wait_core_rst(1'b1, w + GUARD + 20);
      adv_i++;
    end
    wait_drain(20);
    do_stop();
    check("mix_pkt_cnt", pkt_cnt, m_pcnt);
    check("mix_crc_err_cnt", crc_err_cnt, m_ecnt);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
